// File: rtl/panic_flow_classifier_pkg.sv
// Shared definitions for the panic flow classifier.
// Holds the Ethernet/IPv4/UDP header byte offsets inspected on beat 0,
// the protocol constants they are compared against, the class index width
// and the packet-tracking state encoding.
package panic_flow_classifier_pkg;

  localparam int CLASS_W = 5;

  // Byte offsets from the start of the Ethernet frame
  localparam int OFS_ETYPE     = 12;
  localparam int OFS_VER_IHL   = 14;
  localparam int OFS_IPLEN     = 16;
  localparam int OFS_PROTO     = 23;
  localparam int OFS_UDP_DPORT = 36;

  localparam int          ETH_HDR_LEN  = 14;
  localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  VER_IHL_IPV4 = 8'h45;
  localparam logic [7:0]  IPPROTO_UDP  = 8'h11;

  typedef enum logic {
    ST_HEAD,
    ST_BODY
  } state_t;

endpackage

// File: rtl/panic_axis_skid.sv
// Output register plus one skid register for an AXI-stream with a user
// sideband. Latency 1 cycle, full throughput. s_tready is registered and
// equals "skid empty"; a beat accepted while the output is stalled parks in
// the skid register and drains on the next output acceptance.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_tdata/tkeep/tlast/tuser     upstream beat, s_tvalid/s_tready handshake
//   m_tdata/tkeep/tlast/tuser     downstream beat, m_tvalid/m_tready handshake
module panic_axis_skid #(
  parameter int                DATA_W   = 512,
  parameter int                KEEP_W   = 64,
  parameter int                USER_W   = 21,
  parameter logic [USER_W-1:0] USER_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready
);

  localparam int PAY_W = DATA_W + KEEP_W + 1;

  logic             vld_p1;
  logic             skid_vld;
  logic             ready_q;
  logic [PAY_W-1:0] pay_p1;
  logic [PAY_W-1:0] skid_pay;
  logic [USER_W-1:0] user_p1;
  logic [USER_W-1:0] skid_user;
  logic             accept;
  logic             load_p1;
  logic             fill_p1;

  assign accept  = s_tvalid & ready_q;
  assign load_p1 = m_tready | ~vld_p1;
  // Skid and input are never both offered: ready_q is low whenever skid_vld is set
  assign fill_p1 = load_p1 & (skid_vld | accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b0;
      user_p1  <= USER_RST;
    end else begin
      if (load_p1) begin
        vld_p1   <= skid_vld | accept;
        skid_vld <= 1'b0;
      end else if (accept) begin
        skid_vld <= 1'b1;
      end
      ready_q <= load_p1 | ~(skid_vld | accept);
      if (fill_p1) user_p1 <= skid_vld ? skid_user : s_tuser;
    end
  end

  // ---- stage p1: output register, skid register (data, not reset) ----
  always_ff @(posedge clk) begin
    if (fill_p1) pay_p1 <= skid_vld ? skid_pay : {s_tlast, s_tkeep, s_tdata};
    if (!load_p1 && accept) begin
      skid_pay  <= {s_tlast, s_tkeep, s_tdata};
      skid_user <= s_tuser;
    end
  end

  assign s_tready = ready_q;
  assign m_tvalid = vld_p1;
  assign {m_tlast, m_tkeep, m_tdata} = pay_p1;
  assign m_tuser  = user_p1;

endmodule

// File: rtl/panic_flow_classifier.sv
// Inline AXI-stream classifier on the RX path. Parses beat 0 of each
// Ethernet/IPv4/UDP frame, matches the UDP destination port against a
// programmable rule table to pick a flow class, extracts the frame length
// from the IPv4 total length, and forwards the stream unchanged with class
// and length held constant on every beat of the packet.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_axis_*                         input stream (tdata/tkeep/tvalid/tready/tlast)
//   m_axis_*                         output stream, 1-cycle latency
//   m_flow_class, m_pk_len           per-packet metadata, valid with m_axis_tvalid
//   cfg_wr_en/idx/port/enable        rule-table write port
module panic_flow_classifier
  import panic_flow_classifier_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int NUM_RULES       = 5,
  parameter int DEFAULT_CLASS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [CLASS_W-1:0]         m_flow_class,
  output logic [15:0]                m_pk_len,
  input  logic                       cfg_wr_en,
  input  logic [2:0]                 cfg_wr_idx,
  input  logic [15:0]                cfg_wr_port,
  input  logic                       cfg_wr_enable
);

  localparam int USER_W = CLASS_W + 16;

  function automatic logic [7:0] byte_at(input logic [AXIS_DATA_WIDTH-1:0] d, input int idx);
    return d[8*idx +: 8];
  endfunction

  function automatic logic [15:0] sat_u16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  state_t               state, state_n;
  logic [15:0]          rule_port [NUM_RULES];
  logic [NUM_RULES-1:0] rule_en;
  logic                 idx_ok;
  logic                 accept;

  logic [15:0]          etype, iplen, dport;
  logic                 is_ipv4, udp_ok;
  logic [CLASS_W-1:0]   cls_c, cls_q;
  logic [15:0]          len_c, len_q;
  logic [USER_W-1:0]    user_in, user_out;

  assign accept = s_axis_tvalid & s_axis_tready;
  assign idx_ok = ({1'b0, cfg_wr_idx} < 4'(NUM_RULES));

  assign etype   = {byte_at(s_axis_tdata, OFS_ETYPE), byte_at(s_axis_tdata, OFS_ETYPE + 1)};
  assign iplen   = {byte_at(s_axis_tdata, OFS_IPLEN), byte_at(s_axis_tdata, OFS_IPLEN + 1)};
  assign dport   = {byte_at(s_axis_tdata, OFS_UDP_DPORT), byte_at(s_axis_tdata, OFS_UDP_DPORT + 1)};
  assign is_ipv4 = (etype == ETYPE_IPV4);
  assign udp_ok  = is_ipv4
                 && (byte_at(s_axis_tdata, OFS_VER_IHL) == VER_IHL_IPV4)
                 && (byte_at(s_axis_tdata, OFS_PROTO) == IPPROTO_UDP)
                 && s_axis_tkeep[OFS_UDP_DPORT + 1];

  // Descending scan so the lowest matching rule index wins
  always_comb begin
    cls_c = CLASS_W'(DEFAULT_CLASS);
    if (udp_ok) begin
      for (int i = NUM_RULES - 1; i >= 0; i--) begin
        if (rule_en[i] && (rule_port[i] == dport)) cls_c = CLASS_W'(i);
      end
    end
  end

  always_comb begin
    len_c = '0;
    if (is_ipv4 && s_axis_tkeep[OFS_IPLEN + 1])
      len_c = sat_u16({1'b0, iplen} + 17'(ETH_HDR_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HEAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (accept) begin
      case (state)
        ST_HEAD: if (!s_axis_tlast) state_n = ST_BODY;
        ST_BODY: if (s_axis_tlast)  state_n = ST_HEAD;
        default: state_n = ST_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       rule_en <= '0;
    else if (cfg_wr_en && idx_ok)  rule_en[cfg_wr_idx] <= cfg_wr_enable;
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en && idx_ok) rule_port[cfg_wr_idx] <= cfg_wr_port;
  end

  // ---- stage p0: per-packet metadata latched on beat 0 ----
  always_ff @(posedge clk) begin
    if (accept && (state == ST_HEAD)) begin
      cls_q <= cls_c;
      len_q <= len_c;
    end
  end

  assign user_in = (state == ST_HEAD) ? {cls_c, len_c} : {cls_q, len_q};

  panic_axis_skid #(
    .DATA_W   (AXIS_DATA_WIDTH),
    .KEEP_W   (AXIS_KEEP_WIDTH),
    .USER_W   (USER_W),
    .USER_RST ({CLASS_W'(DEFAULT_CLASS), 16'h0000})
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_axis_tdata),
    .s_tkeep  (s_axis_tkeep),
    .s_tlast  (s_axis_tlast),
    .s_tuser  (user_in),
    .s_tvalid (s_axis_tvalid),
    .s_tready (s_axis_tready),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tlast  (m_axis_tlast),
    .m_tuser  (user_out),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );

  assign {m_flow_class, m_pk_len} = user_out;

endmodule

// File: tb/tb_panic_flow_classifier.sv
module tb_panic_flow_classifier;

  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [4:0]    m_flow_class;
  logic [15:0]   m_pk_len;
  logic          cfg_wr_en;
  logic [2:0]    cfg_wr_idx;
  logic [15:0]   cfg_wr_port;
  logic          cfg_wr_enable;

  always #5 clk = ~clk;

  panic_flow_classifier dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_flow_class  (m_flow_class),
    .m_pk_len      (m_pk_len),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_idx    (cfg_wr_idx),
    .cfg_wr_port   (cfg_wr_port),
    .cfg_wr_enable (cfg_wr_enable)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [4:0]    cls;
    logic [15:0]   len;
  } beat_t;

  beat_t cap[$];
  beat_t exp_q[$];
  int    rd_idx = 0;
  int    checks = 0;
  int    errors = 0;
  bit    rand_rdy = 1'b0;

  always @(posedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      cap.push_back('{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast,
                      cls: m_flow_class, len: m_pk_len});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed ...%016h expected ...%016h", tag, got[63:0], expv[63:0]);
    end
  endtask

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DW-1:0] hdr(input logic [15:0] etype, input logic [7:0] ver,
                                        input logic [7:0] proto, input logic [15:0] iplen,
                                        input logic [15:0] dport);
    logic [DW-1:0] d;
    d = rnd512();
    d[8*12 +: 8] = etype[15:8];
    d[8*13 +: 8] = etype[7:0];
    d[8*14 +: 8] = ver;
    d[8*16 +: 8] = iplen[15:8];
    d[8*17 +: 8] = iplen[7:0];
    d[8*23 +: 8] = proto;
    d[8*36 +: 8] = dport[15:8];
    d[8*37 +: 8] = dport[7:0];
    return d;
  endfunction

  task automatic cfg(input logic [2:0] idx, input logic [15:0] port, input logic en);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_port = port; cfg_wr_enable = en;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [4:0] cls, input logic [15:0] len);
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int n = 0; n < 100 && !s_axis_tready; n++) tick();
    chk("s_ready_wait", s_axis_tready, 1);
    tick();
    exp_q.push_back('{data: d, keep: k, last: l, cls: cls, len: len});
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] h, input int n, input logic [4:0] cls,
                          input logic [15:0] len);
    for (int b = 0; b < n; b++) send_beat((b == 0) ? h : rnd512(), '1, (b == n - 1), cls, len);
    idle();
  endtask

  task automatic check_exp(input string tag);
    beat_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int n = 0; n < 200 && rd_idx >= cap.size(); n++) tick();
      chk({tag, "_present"}, (rd_idx < cap.size()), 1);
      if (rd_idx < cap.size()) begin
        g = cap[rd_idx];
        rd_idx++;
        chk_wide({tag, "_data"}, g.data, e.data);
        chk_wide({tag, "_keep"}, DW'(g.keep), DW'(e.keep));
        chk({tag, "_last"}, g.last, e.last);
        chk({tag, "_class"}, g.cls, e.cls);
        chk({tag, "_len"}, g.len, e.len);
      end
    end
    for (int n = 0; n < 5; n++) tick();
    chk({tag, "_no_extra"}, cap.size(), rd_idx);
  endtask

  logic [DW-1:0] b0, b1, b2;
  int            sizes [6] = '{1, 2, 5, 1, 5, 2};

  initial begin
    rst = 1'b1; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_port = '0; cfg_wr_enable = 1'b0;
    tick(); tick(); tick();
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_class", m_flow_class, 4);
    chk("rst_len", m_pk_len, 0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_s_ready", s_axis_tready, 1);

    // 3-beat UDP frame, 1-cycle latency, class 1, length 1486+14
    cfg(3'd1, 16'd4791, 1'b1);
    b0 = hdr(16'h0800, 8'h45, 8'h11, 16'd1486, 16'd4791);
    b1 = rnd512();
    b2 = rnd512();
    send_beat(b0, '1, 1'b0, 5'd1, 16'd1500);
    chk("t1_b0_valid", m_axis_tvalid, 1);
    chk_wide("t1_b0_data", m_axis_tdata, b0);
    chk("t1_b0_class", m_flow_class, 1);
    chk("t1_b0_len", m_pk_len, 1500);
    send_beat(b1, '1, 1'b0, 5'd1, 16'd1500);
    chk_wide("t1_b1_data", m_axis_tdata, b1);
    chk("t1_b1_class", m_flow_class, 1);
    send_beat(b2, 64'h0000_0000_0000_00FF, 1'b1, 5'd1, 16'd1500);
    chk_wide("t1_b2_data", m_axis_tdata, b2);
    chk("t1_b2_last", m_axis_tlast, 1);
    chk("t1_b2_len", m_pk_len, 1500);
    idle();
    tick();
    chk("t1_idle_valid", m_axis_tvalid, 0);
    check_exp("t1");

    // Lowest enabled index wins
    cfg(3'd0, 16'd5000, 1'b1);
    cfg(3'd2, 16'd5000, 1'b1);
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd100, 16'd5000), 2, 5'd0, 16'd114);
    check_exp("prio0");
    cfg(3'd0, 16'd5000, 1'b0);
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd100, 16'd5000), 2, 5'd2, 16'd114);
    check_exp("prio2");

    // ARP single beat, then a fresh UDP frame
    send_beat(hdr(16'h0806, 8'h45, 8'h11, 16'd100, 16'd4791), '1, 1'b1, 5'd4, 16'd0);
    idle();
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd50, 16'd4791), 2, 5'd1, 16'd64);
    check_exp("arp");

    // Ineligible IPv4 frames still report a length
    send_pkt(hdr(16'h0800, 8'h45, 8'h06, 16'd40, 16'd4791), 1, 5'd4, 16'd54);
    send_pkt(hdr(16'h0800, 8'h46, 8'h11, 16'd40, 16'd4791), 1, 5'd4, 16'd54);
    send_beat(hdr(16'h0800, 8'h45, 8'h11, 16'd40, 16'd4791), 64'h0000_001F_FFFF_FFFF, 1'b1, 5'd4, 16'd54);
    send_beat(hdr(16'h0800, 8'h45, 8'h11, 16'd40, 16'd4791), 64'h0000_0000_0001_FFFF, 1'b1, 5'd4, 16'd0);
    idle();
    // Length saturation and near-boundary
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'hFFF8, 16'd4791), 1, 5'd1, 16'hFFFF);
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'hFFF0, 16'd4791), 1, 5'd1, 16'hFFFE);
    // Out-of-range rule index is ignored
    cfg(3'd5, 16'd6000, 1'b1);
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd40, 16'd6000), 1, 5'd4, 16'd54);
    check_exp("elig");

    // Skid fill and drain
    m_axis_tready = 1'b0;
    b0 = hdr(16'h0800, 8'h45, 8'h11, 16'd86, 16'd4791);
    b1 = rnd512();
    send_beat(b0, '1, 1'b0, 5'd1, 16'd100);
    chk("skid_a_valid", m_axis_tvalid, 1);
    chk("skid_a_ready", s_axis_tready, 1);
    send_beat(b1, '1, 1'b1, 5'd1, 16'd100);
    idle();
    chk("skid_full_ready", s_axis_tready, 0);
    chk_wide("skid_hold_a", m_axis_tdata, b0);
    tick();
    chk("skid_stall_ready", s_axis_tready, 0);
    chk_wide("skid_stall_data", m_axis_tdata, b0);
    chk("skid_stall_class", m_flow_class, 1);
    m_axis_tready = 1'b1;
    tick();
    chk("skid_drain_ready", s_axis_tready, 1);
    chk_wide("skid_drain_data", m_axis_tdata, b1);
    chk("skid_drain_last", m_axis_tlast, 1);
    check_exp("skid");

    // Random output backpressure, back-to-back packets
    rand_rdy = 1'b1;
    for (int j = 0; j < 6; j++)
      send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'(200 + j), (j % 2 == 1) ? 16'd5000 : 16'd4791),
               sizes[j], (j % 2 == 1) ? 5'd2 : 5'd1, 16'(214 + j));
    rand_rdy = 1'b0;
    m_axis_tready = 1'b1;
    check_exp("rand");

    // Rule write during beat 1 does not affect that packet
    send_beat(hdr(16'h0800, 8'h45, 8'h11, 16'd66, 16'd80), '1, 1'b0, 5'd4, 16'd80);
    cfg_wr_en = 1'b1; cfg_wr_idx = 3'd3; cfg_wr_port = 16'd80; cfg_wr_enable = 1'b1;
    send_beat(rnd512(), '1, 1'b0, 5'd4, 16'd80);
    cfg_wr_en = 1'b0;
    send_beat(rnd512(), '1, 1'b1, 5'd4, 16'd80);
    idle();
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd66, 16'd80), 2, 5'd3, 16'd80);
    // Write coincident with beat 0 is not seen by that beat
    cfg_wr_en = 1'b1; cfg_wr_idx = 3'd3; cfg_wr_port = 16'd80; cfg_wr_enable = 1'b0;
    send_beat(hdr(16'h0800, 8'h45, 8'h11, 16'd66, 16'd80), '1, 1'b1, 5'd3, 16'd80);
    cfg_wr_en = 1'b0;
    idle();
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd66, 16'd80), 1, 5'd4, 16'd80);
    check_exp("cfgwr");

    // Reset mid-packet with a full skid
    m_axis_tready = 1'b0;
    send_beat(hdr(16'h0800, 8'h45, 8'h11, 16'd86, 16'd4791), '1, 1'b0, 5'd1, 16'd100);
    send_beat(rnd512(), '1, 1'b0, 5'd1, 16'd100);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", m_axis_tvalid, 0);
    chk("mid_rst_ready", s_axis_tready, 0);
    chk("mid_rst_class", m_flow_class, 4);
    chk("mid_rst_len", m_pk_len, 0);
    exp_q.delete();
    rd_idx = cap.size();
    m_axis_tready = 1'b1;
    tick(); tick();
    chk("mid_rst_ready_back", s_axis_tready, 1);
    send_pkt(hdr(16'h0800, 8'h45, 8'h11, 16'd86, 16'd4791), 2, 5'd4, 16'd100);
    check_exp("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
